io_port_scanner: RTL and testbench
==================================

// Module: io_port_scanner
// PURPOSE
//  Physical back end for the 16-byte IO space (addr 0-15; addr[3]=0 -> port 0, addr[3]=1 -> port 1, addr[2:0] = mux slot).
//  Holds per-byte output latches, input captures and direction bits.
//  Time-multiplexes two 8-bit physical ports through 8 external mux slots, driving a shared 3-bit select.
//  Sits directly downstream of the CPU-side IO block, which issues byte reads and writes over a simple strobe interface.
// PARAMETERS
//  SETTLE_CYCLES  4   cycles after a select change, with outputs disabled, before the slot is driven or sampled (>=1)
//  DWELL_CYCLES   16  cycles a slot is active; inputs are sampled on the last dwell cycle (>=1)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  synchronous, active-low reset
//  cpu_addr     in   4  IO byte address
//  cpu_wdata    in   8  write data; bit 0 is also the direction bit for cpu_dir_we
//  cpu_we       in   1  write cpu_wdata into the output latch out_reg[cpu_addr]
//  cpu_dir_we   in   1  write dir_reg[cpu_addr] <= cpu_wdata[0] (1 = output, 0 = input)
//  cpu_re       in   1  read request for cpu_addr
//  cpu_rdata    out  8  read data, registered
//  cpu_rvalid   out  1  one-cycle pulse, valid the cycle after cpu_re
//  mux_sel      out  3  external mux select, shared by both ports
//  port0_out    out  8  drive value, port 0
//  port0_oe     out  1  output enable, port 0
//  port0_in     in   8  pin value, port 0
//  port1_out    out  8  drive value, port 1
//  port1_oe     out  1  output enable, port 1
//  port1_in     in   8  pin value, port 1
//  frame_done   out  1  one-cycle pulse when mux_sel wraps 7 -> 0
// BEHAVIOUR
//  Reset (rst_n low at a clk edge, including mid-scan):
//   - all out_reg, in_reg and dir_reg cleared to 0 (every byte is an input).
//   - mux_sel=0, portN_oe=0, portN_out=0, cpu_rdata=0, cpu_rvalid=0, frame_done=0.
//   - state SETTLE, counter 0; the scan restarts at slot 0 on the first cycle after release.
//  FSM, one shared counter:
//   - SETTLE: oe=0, out=0, lasts SETTLE_CYCLES, then -> DRIVE.
//   - DRIVE: lasts DWELL_CYCLES. On entry, latch active_dir0=dir_reg[{0,sel}] and active_dir1=dir_reg[{1,sel}].
//     portN_oe=active_dirN; portN_out=out_reg[{N,sel}] when active_dirN=1, else 0.
//     On the last DRIVE cycle: in_reg[{N,sel}] <= portN_in for each port with active_dirN=0. Then -> NEXT.
//   - NEXT: one cycle, oe=0 (break-before-make). mux_sel <= mux_sel+1, wrapping 7 -> 0.
//     frame_done=1 in the cycle mux_sel becomes 0. Then -> SETTLE.
//  Slot period = SETTLE+DWELL+1 = 21 cycles at defaults; frame = 8 slots = 168 cycles.
//  portN_out is combinational from out_reg during DRIVE.
//   - A cpu_we to the active output byte appears on the pins the cycle after the write edge.
//  Direction changes to the active slot during DRIVE have no effect until that slot's next visit (latched direction).
//  Read: cpu_rdata <= dir_reg[addr] ? out_reg[addr] : in_reg[addr]; cpu_rvalid pulses one cycle after cpu_re.
//   - A read issued in the capture cycle of the same byte returns the pre-capture value.
//  cpu_we and cpu_dir_we in the same cycle: both apply.
//  cpu_re together with a write to the same address returns the pre-write value.
//  cpu_re held high: rvalid stays high, one read per cycle. No backpressure; writes are never dropped.
//  Capture never touches out_reg; CPU writes never touch in_reg.
// TESTING
//  T1 reset: assert rst_n=0 for 2 cycles mid-DRIVE with port0_oe=1
//     -> next cycle mux_sel=0, oe=0, out=0, cpu_rdata=0; reading any addr returns 0.
//  T2 scan timing, defaults, no writes -> oe stays 0; mux_sel steps every 21 cycles;
//     frame_done is a single-cycle pulse 168 cycles after reset release, repeating every 168.
//  T3 output: dir_we addr 3 wdata 0x01, then we addr 3 wdata 0xA5
//     -> in slot 3 DRIVE, port0_oe=1 and port0_out=0xA5 for exactly 16 cycles; port1_oe=0 throughout.
//  T4 input: port1_in=0x3C during slot 5, addr 0xD left as input
//     -> after the slot, re addr 0xD gives rdata=0x3C with rvalid the next cycle;
//        port1_in changes outside the capture cycle are ignored.
//  T5 live update: we addr 3 0x5A mid-dwell of slot 3 -> port0_out=0x5A next cycle;
//     dir_we addr 3 wdata 0x00 mid-dwell -> oe stays 1 to end of dwell, and is 0 on the next visit.
//  T6 collisions: re addr 0xD in the capture cycle -> old value;
//     we + dir_we same cycle -> both take effect; read issued one cycle later shows both.

Source files
------------

// File: rtl/io_port_scanner.sv
// io_port_scanner: back end for a 16-byte IO space.
// Keeps per-byte output latches, input captures and direction bits, and
// time-multiplexes two 8-bit physical ports across 8 external mux slots.
// Each slot goes through SETTLE (outputs off), DRIVE (dwell), then NEXT
// (outputs off again, select advances).
module io_port_scanner #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DWELL_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    input  logic       cpu_dir_we,
    input  logic       cpu_re,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid,
    output logic [2:0] mux_sel,
    output logic [7:0] port0_out,
    output logic       port0_oe,
    input  logic [7:0] port0_in,
    output logic [7:0] port1_out,
    output logic       port1_oe,
    input  logic [7:0] port1_in,
    output logic       frame_done
);

    // One counter serves both timed phases, so size it for the longer one.
    localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_NEXT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic             frame_done_q, frame_done_d;
    logic [1:0]       act_dir_q, act_dir_d;   // direction latched on DRIVE entry, per port
    logic [7:0]       rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    // Flat views of the per-byte storage held inside the generate blocks.
    logic [7:0] out_arr [16];
    logic [7:0] in_arr  [16];
    logic       dir_arr [16];

    logic [7:0] port_in [2];
    logic       capture;

    assign port_in[0] = port0_in;
    assign port_in[1] = port1_in;

    // Inputs are sampled on the final dwell cycle of the active slot.
    assign capture = (state_q == ST_DRIVE) && (cnt_q == DWELL_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam logic [3:0] IDX = 4'(gi);

            logic [7:0] out_q, out_d;
            logic [7:0] in_q, in_d;
            logic       dir_q, dir_d;

            // Next value of this byte: CPU writes touch only out/dir, capture touches only in.
            always_comb begin
                out_d = out_q;
                in_d  = in_q;
                dir_d = dir_q;
                if (cpu_we && (cpu_addr == IDX)) begin
                    out_d = cpu_wdata;
                end
                if (cpu_dir_we && (cpu_addr == IDX)) begin
                    dir_d = cpu_wdata[0];
                end
                if (capture && (sel_q == IDX[2:0]) && !act_dir_q[IDX[3]]) begin
                    in_d = port_in[IDX[3]];
                end
            end

            // Byte storage; reset makes every byte an input with cleared data.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_q <= '0;
                    in_q  <= '0;
                    dir_q <= 1'b0;
                end else begin
                    out_q <= out_d;
                    in_q  <= in_d;
                    dir_q <= dir_d;
                end
            end

            assign out_arr[gi] = out_q;
            assign in_arr[gi]  = in_q;
            assign dir_arr[gi] = dir_q;
        end
    endgenerate

    // Scan sequencing and CPU read path: next-state computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        sel_d        = sel_q;
        frame_done_d = 1'b0;
        act_dir_d    = act_dir_q;
        case (state_q)
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d   = ST_DRIVE;
                    cnt_d     = '0;
                    // Direction is frozen for the whole dwell; later edits wait for the next visit.
                    act_dir_d = {dir_arr[{1'b1, sel_q}], dir_arr[{1'b0, sel_q}]};
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_NEXT;
                    cnt_d   = '0;
                end
            end
            ST_NEXT: begin
                state_d      = ST_SETTLE;
                cnt_d        = '0;
                sel_d        = sel_q + 3'd1;
                frame_done_d = (sel_q == 3'd7);
            end
            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase

        // Reads see the values before any same-cycle write or capture.
        rvalid_d = cpu_re;
        rdata_d  = rdata_q;
        if (cpu_re) begin
            rdata_d = dir_arr[cpu_addr] ? out_arr[cpu_addr] : in_arr[cpu_addr];
        end
    end

    // Scan FSM and read registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_SETTLE;
            cnt_q        <= '0;
            sel_q        <= 3'd0;
            frame_done_q <= 1'b0;
            act_dir_q    <= 2'b00;
            rdata_q      <= 8'h00;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
            act_dir_q    <= act_dir_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    // Pins are driven only during DRIVE, and only for ports configured as outputs.
    always_comb begin
        port0_oe  = (state_q == ST_DRIVE) && act_dir_q[0];
        port1_oe  = (state_q == ST_DRIVE) && act_dir_q[1];
        port0_out = port0_oe ? out_arr[{1'b0, sel_q}] : 8'h00;
        port1_out = port1_oe ? out_arr[{1'b1, sel_q}] : 8'h00;
    end

    assign mux_sel    = sel_q;
    assign frame_done = frame_done_q;
    assign cpu_rdata  = rdata_q;
    assign cpu_rvalid = rvalid_q;

endmodule

// File: tb/tb_io_port_scanner.sv
// Testbench for io_port_scanner: directed scenarios plus random traffic,
// compared every cycle against a timing model derived from the cycle count.
module tb_io_port_scanner;

    localparam int S = 4;
    localparam int D = 16;
    localparam int P = S + D + 1;   // slot period
    localparam int F = 8 * P;       // frame period

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_we, cpu_dir_we, cpu_re;
    logic [7:0] cpu_rdata;
    logic       cpu_rvalid;
    logic [2:0] mux_sel;
    logic [7:0] port0_out, port1_out, port0_in, port1_in;
    logic       port0_oe, port1_oe, frame_done;

    always #5 clk = ~clk;

    io_port_scanner #(.SETTLE_CYCLES(S), .DWELL_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_dir_we(cpu_dir_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mux_sel(mux_sel),
        .port0_out(port0_out), .port0_oe(port0_oe), .port0_in(port0_in),
        .port1_out(port1_out), .port1_oe(port1_oe), .port1_in(port1_in),
        .frame_done(frame_done)
    );

    // Reference model state: byte arrays plus the cycle index since reset release.
    logic [7:0] out_m [16];
    logic [7:0] in_m  [16];
    logic       dir_m [16];
    logic       adir_m [2];
    logic [7:0] rdata_m;
    logic       rvalid_m;
    int         t;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk = 0;
    bit  hit = 0;
    int  rd_addr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic bit exp_oe(input int port);
        int ph;
        ph = t % P;
        return (ph >= S) && (ph < S + D) && adir_m[port];
    endfunction

    task automatic check_outputs();
        int   slot;
        bit   e0, e1;
        slot = (t / P) % 8;
        e0 = exp_oe(0);
        e1 = exp_oe(1);
        check("mux_sel",    32'(mux_sel),    32'(slot));
        check("port0_oe",   32'(port0_oe),   32'(e0));
        check("port1_oe",   32'(port1_oe),   32'(e1));
        check("port0_out",  32'(port0_out),  e0 ? 32'(out_m[slot])     : 32'h0);
        check("port1_out",  32'(port1_out),  e1 ? 32'(out_m[8 + slot]) : 32'h0);
        check("frame_done", 32'(frame_done), 32'((t > 0) && (t % F == 0)));
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(rvalid_m));
        check("cpu_rdata",  32'(cpu_rdata),  32'(rdata_m));
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        int ph, slot;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                out_m[i] = 8'h00;
                in_m[i]  = 8'h00;
                dir_m[i] = 1'b0;
            end
            adir_m[0] = 1'b0;
            adir_m[1] = 1'b0;
            rdata_m   = 8'h00;
            rvalid_m  = 1'b0;
            t         = 0;
            return;
        end
        ph   = t % P;
        slot = (t / P) % 8;
        if (cpu_re) rdata_m = dir_m[cpu_addr] ? out_m[cpu_addr] : in_m[cpu_addr];
        rvalid_m = cpu_re;
        if (ph == S - 1) begin
            adir_m[0] = dir_m[slot];
            adir_m[1] = dir_m[8 + slot];
        end
        if (ph == S + D - 1) begin
            if (!adir_m[0]) in_m[slot]     = port0_in;
            if (!adir_m[1]) in_m[8 + slot] = port1_in;
        end
        if (cpu_we)     out_m[cpu_addr] = cpu_wdata;
        if (cpu_dir_we) dir_m[cpu_addr] = cpu_wdata[0];
        t++;
    endtask

    task automatic drive_idle();
        rst_n      = 1'b1;
        cpu_we     = 1'b0;
        cpu_dir_we = 1'b0;
        cpu_re     = 1'b0;
        cpu_addr   = 4'h0;
        cpu_wdata  = 8'h00;
        port0_in   = 8'($urandom);
        port1_in   = 8'($urandom);
    endtask

    task automatic random_traffic();
        cpu_addr   = 4'($urandom_range(0, 15));
        cpu_wdata  = 8'($urandom);
        cpu_we     = ($urandom_range(0, 7) == 0);
        cpu_dir_we = ($urandom_range(0, 7) == 0);
        cpu_re     = ($urandom_range(0, 2) == 0);
    endtask

    task automatic directed();
        case (t)
            1:                 begin cpu_dir_we = 1; cpu_addr = 4'h3; cpu_wdata = 8'h01; end
            2:                 begin cpu_we = 1;     cpu_addr = 4'h3; cpu_wdata = 8'hA5; end
            10:                begin cpu_we = 1; cpu_dir_we = 1; cpu_addr = 4'h7; cpu_wdata = 8'h81; end
            11:                begin cpu_re = 1; cpu_addr = 4'h7; end
            3*P + S + 8:       begin cpu_we = 1;     cpu_addr = 4'h3; cpu_wdata = 8'h5A; end
            3*P + S + 10:      begin cpu_dir_we = 1; cpu_addr = 4'h3; cpu_wdata = 8'h00; end
            5*P + S + D - 1:   begin cpu_re = 1; cpu_addr = 4'hD; port1_in = 8'h3C; end
            5*P + S + D:       begin cpu_re = 1; cpu_addr = 4'hD; end
            default: ;
        endcase
    endtask

    // mode: 0 directed, 1 random, 2 idle, 3 reset, 4 random until port0 drives then reset, 5 read rd_addr
    task automatic run_cycle(input int mode);
        @(negedge clk);
        if (chk) check_outputs();
        drive_idle();
        case (mode)
            0: directed();
            1: random_traffic();
            3: rst_n = 1'b0;
            4: begin
                random_traffic();
                if (exp_oe(0)) begin
                    rst_n = 1'b0;
                    hit   = 1;
                end
            end
            5: begin cpu_re = 1; cpu_addr = 4'(rd_addr); end
            default: ;
        endcase
        model_edge();
        chk = 1;
    endtask

    initial begin
        t = 0;
        drive_idle();
        rst_n = 1'b0;
        run_cycle(3);
        run_cycle(3);

        // Directed: output slot, input capture, live update, collisions, two frames.
        for (int i = 0; i < 2 * F + 10; i++) run_cycle(0);

        // Random CPU traffic against the running scan.
        for (int i = 0; i < 5 * F; i++) run_cycle(1);

        // Reset while port 0 is actively driving.
        for (int i = 0; i < 4 * F && !hit; i++) run_cycle(4);
        run_cycle(3);
        check("reset_hit_drive", 32'(hit), 32'd1);

        // Every byte reads back as zero after reset.
        for (int a = 0; a < 16; a++) begin
            rd_addr = a;
            run_cycle(5);
        end
        for (int i = 0; i < F + 5; i++) run_cycle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
